// File: rtl/sc_multiport_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: default widths, the counter
// ceiling, and small decode helpers used by the top and its per-register cells.
package sc_pkg;

  localparam int SC_REG_ADDR_W = 7;
  localparam int SC_NUM_WB     = 2;
  localparam int SC_CNT_W      = 2;
  localparam int CNT_MAX       = (1 << SC_CNT_W) - 1;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

  // Register 0 is hardwired free, so an address equal to 0 never decodes.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] idx);
    return (addr == idx) && (addr != 32'd0);
  endfunction

endpackage

// File: rtl/sc_multiport_scoreboard_if.sv
// Issue and write-back bus between decode/issue, the execution units and the
// register scoreboard.
interface sc_multiport_scoreboard_if
  import sc_pkg::*;
#(
  parameter int REG_ADDR_W = SC_REG_ADDR_W,
  parameter int NUM_WB     = SC_NUM_WB
);
  // Issue handshake: an instruction fires in a cycle where iss_valid && iss_ready.
  // iss_ready never looks at iss_valid, and the issuer holds its fields stable
  // while iss_valid is high and iss_ready is low.
  logic                         iss_valid;
  logic                         iss_ready;
  logic [REG_ADDR_W-1:0]        iss_rs1;
  logic [REG_ADDR_W-1:0]        iss_rs2;
  logic [REG_ADDR_W-1:0]        iss_rs3;
  logic [2:0]                   iss_rs_en;
  logic [REG_ADDR_W-1:0]        iss_rd;
  logic                         iss_rd_en;
  logic [NUM_WB-1:0]            wb_valid;
  logic [NUM_WB*REG_ADDR_W-1:0] wb_rd;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rs3, iss_rs_en, iss_rd, iss_rd_en,
    output wb_valid, wb_rd,
    input  iss_ready
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rs3, iss_rs_en, iss_rd, iss_rd_en,
    input  wb_valid, wb_rd,
    output iss_ready
  );

endinterface

// File: rtl/sc_multiport_scoreboard_pend_cell.sv
// Pending-write counter for one architectural register: +1 on issue, minus the
// number of same-cycle releases, clamped at zero with an underflow pulse.
module sc_pend_cell #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec_n,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_after_release,
  output logic             uflow
);

  localparam int XW = (CNT_W > DEC_W) ? CNT_W : DEC_W;

  logic [XW-1:0]    cnt_x;
  logic [XW-1:0]    dec_x;
  logic [CNT_W-1:0] cnt_d;

  // Releases are applied to the registered count before the issue increment,
  // so a release with nothing outstanding is an underflow even if an issue lands.
  always_comb begin
    cnt_x             = XW'(cnt);
    dec_x             = XW'(dec_n);
    cnt_after_release = (dec_x > cnt_x) ? '0 : CNT_W'(cnt_x - dec_x);
    uflow             = !flush && (dec_x > cnt_x);
    cnt_d             = flush ? '0 : cnt_after_release + CNT_W'(inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_d;
  end

endmodule

// File: rtl/sc_multiport_scoreboard.sv
// Register scoreboard: RAW/saturation issue gating with NUM_WB release ports.
// Optional SC_WB_BYPASS_EN lets same-cycle releases clear a hazard immediately.
module sc_multiport_scoreboard
  import sc_pkg::*;
#(
  parameter int REG_ADDR_W = SC_REG_ADDR_W,
  parameter int NUM_WB     = SC_NUM_WB,
  parameter int CNT_W      = SC_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  sc_multiport_scoreboard_if.slave  bus,
  output logic                      busy_any,
  output logic [31:0]               stall_cnt,
  output logic                      err_uflow
);

  localparam int               NUM_REGS = 1 << REG_ADDR_W;
  localparam int               DEC_W    = $clog2(NUM_WB + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = '1;

  logic [CNT_W-1:0]    cnt_q    [NUM_REGS];
  logic [CNT_W-1:0]    cnt_rel  [NUM_REGS];
  logic [CNT_W-1:0]    cnt_view [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] uflow;
  logic [NUM_REGS-1:0] nz_nxt;
  logic [2:0]          rs_hit;
  logic                hazard;
  logic                sat;
  logic                fire;

  always_comb begin
    rs_hit[0] = bus.iss_rs_en[0] && (bus.iss_rs1 != '0) && (cnt_view[bus.iss_rs1] != '0);
    rs_hit[1] = bus.iss_rs_en[1] && (bus.iss_rs2 != '0) && (cnt_view[bus.iss_rs2] != '0);
    rs_hit[2] = bus.iss_rs_en[2] && (bus.iss_rs3 != '0) && (cnt_view[bus.iss_rs3] != '0);
    hazard    = |rs_hit;
    sat       = bus.iss_rd_en && (bus.iss_rd != '0) && (cnt_view[bus.iss_rd] == CNT_FULL);
  end

  assign bus.iss_ready = rst_n && !flush && !hazard && !sat;
  assign fire          = bus.iss_valid && bus.iss_ready;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic [NUM_WB-1:0] wb_hit;

    always_comb begin
      for (int i = 0; i < NUM_WB; i++)
        wb_hit[i] = bus.wb_valid[i] &&
                    addr_hit(32'(bus.wb_rd[i*REG_ADDR_W +: REG_ADDR_W]), 32'(r));
    end

    assign inc[r] = fire && bus.iss_rd_en && addr_hit(32'(bus.iss_rd), 32'(r));

    sc_pend_cell #(
      .CNT_W (CNT_W),
      .DEC_W (DEC_W)
    ) u_cell (
      .clk               (clk),
      .rst_n             (rst_n),
      .inc               (inc[r]),
      .dec_n             (DEC_W'(popcount(32'(wb_hit)))),
      .flush             (flush),
      .cnt               (cnt_q[r]),
      .cnt_after_release (cnt_rel[r]),
      .uflow             (uflow[r])
    );

    // Next count is cnt_rel + inc, so it is non-zero iff either term is.
    assign nz_nxt[r] = !flush && ((cnt_rel[r] != '0) || inc[r]);

`ifdef SC_WB_BYPASS_EN
    assign cnt_view[r] = cnt_rel[r];
`else
    assign cnt_view[r] = cnt_q[r];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_any  <= 1'b0;
      stall_cnt <= '0;
      err_uflow <= 1'b0;
    end else begin
      busy_any <= |nz_nxt;
      if (bus.iss_valid && !bus.iss_ready && !flush && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (|uflow)
        err_uflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sc_multiport_scoreboard.sv
// Directed bench for sc_multiport_scoreboard; expectations adapt to
// SC_WB_BYPASS_EN when that macro is defined for the build.
module tb_sc_multiport_scoreboard;

  localparam int W   = 7;
  localparam int NWB = 2;
  localparam int CW  = 2;
`ifdef SC_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  localparam logic [31:0] T1_STALL = BYP ? 32'd2 : 32'd3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        busy_any;
  logic [31:0] stall_cnt;
  logic        err_uflow;
  int          vecs = 0;
  int          errs = 0;

  sc_multiport_scoreboard_if #(.REG_ADDR_W(W), .NUM_WB(NWB)) bus ();

  sc_multiport_scoreboard #(.REG_ADDR_W(W), .NUM_WB(NWB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .busy_any  (busy_any),
    .stall_cnt (stall_cnt),
    .err_uflow (err_uflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_rs1   = '0;
    bus.iss_rs2   = '0;
    bus.iss_rs3   = '0;
    bus.iss_rs_en = '0;
    bus.iss_rd    = '0;
    bus.iss_rd_en = 1'b0;
    bus.wb_valid  = '0;
    bus.wb_rd     = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #12;
    chk("rst_ready", 32'(bus.iss_ready), 32'd0);
    chk("rst_busy",  32'(busy_any),      32'd0);
    chk("rst_stall", stall_cnt,          32'd0);
    chk("rst_err",   32'(err_uflow),     32'd0);
    rst_n = 1'b1;
    tick();

    // RAW on reg 5 released by write-back port 0
    bus.iss_valid = 1'b1; bus.iss_rd = 7'd5; bus.iss_rd_en = 1'b1;
    #1 chk("t1_issue_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    bus.iss_rd_en = 1'b0; bus.iss_rs1 = 7'd5; bus.iss_rs_en = 3'b001;
    #1 chk("t1_raw_ready", 32'(bus.iss_ready), 32'd0);
    chk("t1_busy_set", 32'(busy_any), 32'd1);
    tick();
    #1 chk("t1_raw_ready2", 32'(bus.iss_ready), 32'd0);
    tick();
    bus.wb_valid = 2'b01; bus.wb_rd = {7'd0, 7'd5};
    #1 chk("t1_wb_cycle_ready", 32'(bus.iss_ready), 32'(BYP));
    tick();
    bus.wb_valid = '0;
    #1 chk("t1_release_ready", 32'(bus.iss_ready), 32'd1);
    chk("t1_busy_clr", 32'(busy_any), 32'd0);
    chk("t1_stall", stall_cnt, T1_STALL);
    tick();
    idle();

    // Saturation of reg 7 at three in-flight writes
    bus.iss_valid = 1'b1; bus.iss_rd = 7'd7; bus.iss_rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t2_fill_ready", 32'(bus.iss_ready), 32'd1);
      tick();
    end
    bus.iss_valid = 1'b0;
    #1 chk("t2_sat_ready", 32'(bus.iss_ready), 32'd0);
    bus.wb_valid = 2'b10; bus.wb_rd = {7'd7, 7'd0};
    #1 chk("t2_wb_cycle_ready", 32'(bus.iss_ready), 32'(BYP));
    tick();
    bus.wb_valid = '0;
    #1 chk("t2_after_wb_ready", 32'(bus.iss_ready), 32'd1);
    bus.iss_rd_en = 1'b0; bus.wb_valid = 2'b11; bus.wb_rd = {7'd7, 7'd7};
    tick();
    idle();
    #1 chk("t2_drain_busy", 32'(busy_any), 32'd0);
    chk("t2_drain_err", 32'(err_uflow), 32'd0);

    // Dual-port release of reg 9 holding two writes
    bus.iss_valid = 1'b1; bus.iss_rd = 7'd9; bus.iss_rd_en = 1'b1;
    tick();
    tick();
    idle();
    #1 chk("t3_busy_set", 32'(busy_any), 32'd1);
    bus.wb_valid = 2'b11; bus.wb_rd = {7'd9, 7'd9};
    tick();
    bus.wb_valid = '0;
    #1 chk("t3_busy_clr", 32'(busy_any), 32'd0);
    chk("t3_err", 32'(err_uflow), 32'd0);
    bus.iss_rs1 = 7'd9; bus.iss_rs_en = 3'b001;
    #1 chk("t3_rs_ready", 32'(bus.iss_ready), 32'd1);
    idle();

    // Underflow on reg 12, then traffic on reg 0
    bus.wb_valid = 2'b01; bus.wb_rd = {7'd0, 7'd12};
    tick();
    bus.wb_valid = '0;
    #1 chk("t4_err_set", 32'(err_uflow), 32'd1);
    chk("t4_busy", 32'(busy_any), 32'd0);
    tick();
    #1 chk("t4_err_held", 32'(err_uflow), 32'd1);
    bus.iss_rs1 = 7'd12; bus.iss_rs_en = 3'b001;
    #1 chk("t4_rs12_ready", 32'(bus.iss_ready), 32'd1);
    bus.iss_valid = 1'b1; bus.iss_rd = 7'd0; bus.iss_rd_en = 1'b1;
    bus.iss_rs1 = 7'd0; bus.iss_rs2 = 7'd0; bus.iss_rs_en = 3'b011;
    #1 chk("t4_r0_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    idle();
    bus.wb_valid = 2'b01; bus.wb_rd = '0;
    tick();
    bus.wb_valid = '0;
    #1 chk("t4_r0_busy", 32'(busy_any), 32'd0);
    chk("t4_r0_stall", stall_cnt, T1_STALL);

    // Flush with a simultaneous issue of rd=6
    bus.iss_valid = 1'b1; bus.iss_rd_en = 1'b1;
    bus.iss_rd = 7'd3; tick();
    bus.iss_rd = 7'd4; tick();
    bus.iss_rd = 7'd5; tick();
    bus.iss_rd = 7'd6; flush = 1'b1;
    #1 chk("t5_busy_before", 32'(busy_any), 32'd1);
    chk("t5_flush_ready", 32'(bus.iss_ready), 32'd0);
    tick();
    flush = 1'b0;
    idle();
    #1 chk("t5_busy_after", 32'(busy_any), 32'd0);
    chk("t5_err_kept", 32'(err_uflow), 32'd1);
    chk("t5_stall_kept", stall_cnt, T1_STALL);
    bus.iss_rs1 = 7'd3; bus.iss_rs2 = 7'd6; bus.iss_rs3 = 7'd5; bus.iss_rs_en = 3'b111;
    #1 chk("t5_srcs_ready", 32'(bus.iss_ready), 32'd1);
    idle();

    // Asynchronous reset in the middle of a stall on reg 8
    bus.iss_valid = 1'b1; bus.iss_rd = 7'd8; bus.iss_rd_en = 1'b1;
    tick();
    bus.iss_rd_en = 1'b0; bus.iss_rs1 = 7'd8; bus.iss_rs_en = 3'b001;
    repeat (10) tick();
    #1 chk("t6_stall_ready", 32'(bus.iss_ready), 32'd0);
    chk("t6_stall_cnt", stall_cnt, T1_STALL + 32'd10);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_stall", stall_cnt, 32'd0);
    chk("t6_rst_err", 32'(err_uflow), 32'd0);
    chk("t6_rst_ready", 32'(bus.iss_ready), 32'd0);
    chk("t6_rst_busy", 32'(busy_any), 32'd0);
    #2 rst_n = 1'b1;
    #1 chk("t6_post_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    #1 chk("t6_post_stall", stall_cnt, 32'd0);
    chk("t6_post_busy", 32'(busy_any), 32'd0);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
